// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg
//   Shared widths, reset value and IF/ID record for the LEGv8 front end.
//   Revision: 1.0
// ============================================================================
package core_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;
  localparam int IMEM_AW = 6;

  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 64'h0;
  // A64 NOP encoding, used by later stages to fill bubbles
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'hD503_201F;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } if_id_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_pc_reg.sv
`default_nettype none
// ============================================================================
// pc_reg
//   Program counter with redirect / +4 / hold selection and a sticky flag
//   recording any redirect target that was not word aligned.
//   Revision: 1.0
// ============================================================================
module pc_reg
  import core_pkg::*;
#(
  parameter int              N        = PC_W,
  parameter logic [N-1:0]    RESET_PC = N'(RESET_PC_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  input  logic         advance,
  output logic [N-1:0] pc,
  output logic         misalign
);

  logic [N-1:0] pc_d, pc_q;
  logic         misalign_d, misalign_q;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (br_taken) begin
      // Low bits are dropped so fetch stays word aligned; the flag records it
      pc_d = {br_target[N-1:2], 2'b00};
      if (br_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (advance) begin
      pc_d = pc_q + N'(4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign misalign = misalign_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage
//   LEGv8 instruction fetch: drives imem, registers instruction + PC into the
//   IF/ID register with a valid/ready handshake, and honours redirects.
//   Revision: 1.0
// ============================================================================
module fetch_stage
  import core_pkg::*;
#(
  parameter int           N        = PC_W,
  parameter int           IW       = INSTR_W,
  parameter int           AW       = IMEM_AW,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_q,
  input  logic          br_taken,
  input  logic [N-1:0]  br_target,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [IW-1:0] instr_out,
  output logic [N-1:0]  pc_out,
  output logic          misalign,
  output logic [31:0]   fetch_count
);

  logic [N-1:0]  pc;
  logic          advance;
  logic          transfer;

  logic          out_valid_d,   out_valid_q;
  logic [IW-1:0] instr_out_d,   instr_out_q;
  logic [N-1:0]  pc_out_d,      pc_out_q;
  logic [31:0]   fetch_count_d, fetch_count_q;

  assign advance  = !out_valid_q || out_ready;
  assign transfer = out_valid_q && out_ready;

  pc_reg #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .br_taken  (br_taken),
    .br_target (br_target),
    .advance   (advance),
    .pc        (pc),
    .misalign  (misalign)
  );

  assign imem_addr = pc[AW+1:2];

  always_comb begin
    out_valid_d = out_valid_q;
    instr_out_d = instr_out_q;
    pc_out_d    = pc_out_q;
    if (br_taken) begin
      // Squash whatever sits in IF/ID, even mid-stall; payload is left as is
      out_valid_d = 1'b0;
    end else if (advance) begin
      out_valid_d = 1'b1;
      instr_out_d = imem_q;
      pc_out_d    = pc;
    end
  end

  // Counts consumed instructions, including one taken on a redirect edge
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (transfer && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      instr_out_q   <= '0;
      pc_out_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      instr_out_q   <= instr_out_d;
      pc_out_q      <= pc_out_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign instr_out   = instr_out_q;
  assign pc_out      = pc_out_q;
  assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage
//   Randomised + directed bench for fetch_stage with a transfer scoreboard.
//   Revision: 1.0
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        br_taken;
  logic [63:0] br_target;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] instr_out;
  logic [63:0] pc_out;
  logic        misalign;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .misalign    (misalign),
    .fetch_count (fetch_count)
  );

  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
  assign imem_q = mem[imem_addr];

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: decode sees a stream of consecutive words that restarts at
  // each aligned redirect target; one slot sits between imem and decode.
  logic        m_valid;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_next;
  logic        m_mis;
  logic [31:0] m_count;

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    return 32'h1000_0000 + 32'((a >> 2) % 64);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = 64'h0;
    m_instr = 32'h0;
    m_next  = 64'h0;
    m_mis   = 1'b0;
    m_count = 32'h0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"},  64'(out_valid),   64'(m_valid));
    chk({tag, "_pc"},     pc_out,           m_pc);
    chk({tag, "_instr"},  64'(instr_out),   64'(m_instr));
    chk({tag, "_mis"},    64'(misalign),    64'(m_mis));
    chk({tag, "_count"},  64'(fetch_count), 64'(m_count));
    chk({tag, "_iaddr"},  64'(imem_addr),   (m_next >> 2) % 64);
  endtask

  // Called at posedge+2; drives one cycle and advances the model over that edge
  task automatic step(input bit br, input logic [63:0] tgt, input bit rdy);
    br_taken  = br;
    br_target = tgt;
    out_ready = rdy;
    if (m_valid && rdy) begin
      sb.push_back('{m_pc, m_instr});
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    end
    if (br) begin
      m_valid = 1'b0;
      m_next  = {tgt[63:2], 2'b00};
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
    end else if (!m_valid || rdy) begin
      m_pc    = m_next;
      m_instr = rom_word(m_next);
      m_valid = 1'b1;
      m_next  = m_next + 64'd4;
    end
    @(posedge clk);
    #2;
    check_state("step");
  endtask

  // Monitor: any handshake presented to decode must match the next expected word
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL xfer_unexpected: got pc %h expected no transfer", pc_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("xfer_pc",    pc_out,          e.pc);
          chk("xfer_instr", 64'(instr_out),  64'(e.instr));
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    br_taken  = 1'b0;
    br_target = 64'h0;
    out_ready = 1'b0;
    model_reset();

    @(posedge clk); #2;
    check_state("reset");
    @(posedge clk); #2;
    reset = 1'b1;

    // Stream four instructions into decode
    for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 1'b1);
    chk("count_after_stream", 64'(fetch_count), 64'd4);

    // Stall with a valid instruction held, then release
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 64'h0, 1'b1);

    // Redirect while decode is accepting, then while stalled
    step(1'b1, 64'h40, 1'b1);
    chk("bubble_after_redirect", 64'(out_valid), 64'd0);
    step(1'b0, 64'h0, 1'b1);
    chk("redirect_pc",    pc_out,         64'h40);
    chk("redirect_instr", 64'(instr_out), 64'h1000_0010);
    step(1'b0, 64'h0, 1'b0);
    step(1'b0, 64'h0, 1'b0);
    step(1'b1, 64'h80, 1'b0);
    step(1'b0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b1);

    // Misaligned target is aligned down and the flag sticks
    step(1'b1, 64'h42, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    chk("misalign_pc", pc_out, 64'h40);
    step(1'b1, 64'h10, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    chk("misalign_sticky", 64'(misalign), 64'd1);

    // imem address wraps while pc keeps counting
    step(1'b1, 64'hF8, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1);

    // Full 64-bit pc wrap
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bit rdy, br;
      logic [63:0] tgt;
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 9) == 0);
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) tgt = tgt & 64'h0000_0000_0000_03FF;
      step(br, tgt, rdy);
    end

    // Asynchronous reset between edges
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk("async_valid", 64'(out_valid),   64'd0);
    chk("async_pc",    pc_out,           64'd0);
    chk("async_count", 64'(fetch_count), 64'd0);
    chk("async_mis",   64'(misalign),    64'd0);
    chk("async_iaddr", 64'(imem_addr),   64'd0);
    br_taken  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1;
    step(1'b0, 64'h0, 1'b1);
    chk("resume_pc",    pc_out,         64'h0);
    chk("resume_instr", 64'(instr_out), 64'h1000_0000);
    for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1);

    out_ready = 1'b0;
    @(negedge clk); #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
